// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths and FSM state encoding for the 12-bit audio unpacker
package audio_pkg;

  localparam int SAMPLE_WIDTH = 24;
  localparam int WORD_WIDTH   = 12;

  typedef enum logic [2:0] {
    IDLE_HI,
    WAIT_HI,
    IDLE_LO,
    WAIT_LO,
    HOLD
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/audio_unpack12.sv
// rtl/audio_unpack12.sv - joins pairs of 12-bit FIFO words into 24-bit L/R samples
module audio_unpack12
  import audio_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_WIDTH-1:0]   fifo_q,
  input  logic                    fifo_empty,
  output logic                    fifo_rden,
  input  logic                    resync,
  output logic [SAMPLE_WIDTH-1:0] sample_data,
  output logic                    sample_ch,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic [CNT_WIDTH-1:0]    underrun_cnt
);

  state_t                state;
  logic [WORD_WIDTH-1:0] hi;
  logic                  read_state;
  logic                  underrun;

  // Reads are suppressed under rst/resync so no word is fetched only to be dropped.
  assign read_state = (state == IDLE_HI) || (state == WAIT_HI) || (state == IDLE_LO);
  assign fifo_rden  = !rst && !resync && !fifo_empty && read_state;
  assign underrun   = !rst && !resync && (state == WAIT_HI) && fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE_HI;
      hi           <= '0;
      sample_data  <= '0;
      sample_ch    <= 1'b0;
      sample_valid <= 1'b0;
    end else if (resync) begin
      state        <= IDLE_HI;
      hi           <= '0;
      sample_ch    <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      case (state)
        IDLE_HI: begin
          if (!fifo_empty) state <= WAIT_HI;
        end
        WAIT_HI: begin
          hi    <= fifo_q;
          state <= fifo_empty ? IDLE_LO : WAIT_LO;
        end
        IDLE_LO: begin
          if (!fifo_empty) state <= WAIT_LO;
        end
        WAIT_LO: begin
          sample_data  <= {hi, fifo_q};
          sample_valid <= 1'b1;
          state        <= HOLD;
        end
        HOLD: begin
          if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
            sample_ch    <= ~sample_ch;
            state        <= IDLE_HI;
          end
        end
        default: state <= IDLE_HI;
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_underrun_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (underrun),
    .count (underrun_cnt)
  );

endmodule

// File: doc/audio_unpack12.md
AUDIO_UNPACK12 -- requirements
Module: audio_unpack12

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the underrun event counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge, same domain as the FIFO read side.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port fifo_q, input, 12, FIFO read data, valid exactly one clk after a cycle with fifo_rden=1.
REQ-005 SHALL have port fifo_empty, input, 1, FIFO empty flag.
REQ-006 SHALL have port fifo_rden, output, 1, FIFO read strobe.
REQ-007 SHALL have port resync, input, 1, aborts the partial sample and forces the next sample to channel L.
REQ-008 SHALL have port sample_data, output, 24, assembled audio sample {hi word, lo word}.
REQ-009 SHALL have port sample_ch, output, 1, channel of sample_data (0=L, 1=R).
REQ-010 SHALL have port sample_valid, output, 1, sample handshake valid.
REQ-011 SHALL have port sample_ready, input, 1, sample handshake ready from the consumer.
REQ-012 SHALL have port underrun_cnt, output, CNT_WIDTH, saturating count of mid-sample underruns.

Function
REQ-013 SHALL implement FSM states IDLE_HI, WAIT_HI, IDLE_LO, WAIT_LO, HOLD.
REQ-014 IDLE_HI: fifo_empty=0 -> fifo_rden=1, go to WAIT_HI; otherwise stay with fifo_rden=0.
REQ-015 WAIT_HI: capture fifo_q into the hi register; fifo_empty=0 -> fifo_rden=1, go to WAIT_LO; otherwise go to IDLE_LO and increment underrun_cnt.
REQ-016 IDLE_LO: fifo_empty=0 -> fifo_rden=1, go to WAIT_LO; otherwise stay, and do not increment the counter again.
REQ-017 WAIT_LO: capture fifo_q as the lo word; on the next edge sample_data={hi,lo} and sample_valid=1; go to HOLD.
REQ-018 HOLD: sample_data, sample_ch and sample_valid SHALL remain stable until a cycle with sample_valid=1 and sample_ready=1.
REQ-019 On that HOLD transfer cycle: clear sample_valid next cycle, toggle sample_ch, go to IDLE_HI.
REQ-020 fifo_rden SHALL be combinational from state and fifo_empty, and SHALL never be 1 while fifo_empty=1.
REQ-021 fifo_rden SHALL be 1 only in IDLE_HI, WAIT_HI or IDLE_LO.
REQ-022 Best-case throughput SHALL be one sample per 4 clk with sample_ready held high; latency is 3 clk from the first fifo_rden to sample_valid.
REQ-023 underrun_cnt SHALL saturate at all-ones and SHALL never wrap.
REQ-024 resync=1 in any state SHALL, next cycle:
- state=IDLE_HI, sample_valid=0, sample_ch=0, hi register cleared;
- any in-flight FIFO word is discarded, not captured;
- fifo_rden=0 in the resync cycle;
- underrun_cnt is unchanged.
REQ-025 resync SHALL take priority over a simultaneous HOLD transfer: that sample counts as transferred, but sample_ch is forced to 0 rather than toggled.
REQ-026 sample_ready=1 while sample_valid=0 SHALL have no effect.

Reset
REQ-027 rst=1 SHALL set, next edge: state=IDLE_HI, fifo_rden=0, sample_valid=0, sample_ch=0, sample_data=0, hi=0, underrun_cnt=0.
REQ-028 rst SHALL override resync and all handshake inputs; reset mid-sample discards the partial sample and any in-flight FIFO word.

Structure
REQ-029 The FSM state enum and the SAMPLE_WIDTH=24 / WORD_WIDTH=12 constants SHALL live in a shared package, audio_pkg.
REQ-030 A single flat module is natural; a saturating counter sub-module, sat_counter, is permitted.

Verification
REQ-031 Preload FIFO with 0xABC,0x123,0x456,0x789; sample_ready=1 -> samples 0xABC123 ch0 then 0x456789 ch1; underrun_cnt=0.
REQ-032 FIFO holds only 0x111; second word 0x222 arrives 10 clk later -> underrun_cnt=1 (not 10); output is 0x111222 ch0.
REQ-033 sample_ready=0 for 20 clk after valid -> sample_data/sample_ch stable; fifo_rden=0 for the whole period.
REQ-034 resync pulse in WAIT_LO after hi=0xFFF -> word discarded; next pair 0x00A,0x00B yields 0x00A00B ch0.
REQ-035 Force 2^CNT_WIDTH+3 underruns with CNT_WIDTH=4 -> underrun_cnt stays at 0xF; rst -> 0.
REQ-036 fifo_empty=1 held throughout with random resync -> fifo_rden never asserted, sample_valid stays 0.
